// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, one step per cycle, single-cycle result beat on completion.
module ex_muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [4:0]      in_rd_addr,
  input  logic            flush,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd_addr
);

  localparam int unsigned ACC_W = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         f3_q;
  logic [4:0]         rd_q;
  logic               neg_q_q;   // negate product / quotient
  logic               neg_r_q;   // negate remainder
  logic [XLEN-1:0]    op_q;      // multiplicand or divisor magnitude
  logic [ACC_W-1:0]   acc_q;

  logic accept, step, last;

  // Operand decode for the instruction presented in EX
  logic            a_signed, b_signed, a_neg, b_neg, is_div_in;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    a_signed  = (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                (in_funct3 == 3'b100) || (in_funct3 == 3'b110);
    b_signed  = (in_funct3 == 3'b001) || (in_funct3 == 3'b100) || (in_funct3 == 3'b110);
    a_neg     = a_signed && in_rs1_data[XLEN-1];
    b_neg     = b_signed && in_rs2_data[XLEN-1];
    a_mag     = a_neg ? (~in_rs1_data + XLEN'(1)) : in_rs1_data;
    b_mag     = b_neg ? (~in_rs2_data + XLEN'(1)) : in_rs2_data;
    is_div_in = in_funct3[2];
    div_zero  = is_div_in && (in_rs2_data == '0);
    div_ovf   = is_div_in && !in_funct3[0] && (in_rs1_data == MIN_NEG) && (&in_rs2_data);
    special   = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)     special_res = in_funct3[1] ? in_rs1_data : '1;
    else if (div_ovf) special_res = in_funct3[1] ? '0 : MIN_NEG;
  end

  // One radix-2 step: multiply shifts the multiplier out of the low half,
  // divide shifts the dividend out of the low half into the remainder.
  logic [XLEN:0]      mul_sum, div_shift, div_diff;
  logic [ACC_W-1:0]   mul_next, div_next, acc_step, prod;
  logic [XLEN-1:0]    quo, rem, final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[ACC_W-1:XLEN-1];
    div_diff  = div_shift - {1'b0, op_q};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    acc_step  = f3_q[2] ? div_next : mul_next;
    prod      = neg_q_q ? (~acc_step + ACC_W'(1)) : acc_step;
    quo       = neg_q_q ? (~acc_step[XLEN-1:0] + XLEN'(1)) : acc_step[XLEN-1:0];
    rem       = neg_r_q ? (~acc_step[ACC_W-1:XLEN] + XLEN'(1)) : acc_step[ACC_W-1:XLEN];
    case (f3_q)
      3'b000:          final_res = prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:          final_res = prod[ACC_W-1:XLEN];
      3'b100, 3'b101:  final_res = quo;
      default:         final_res = rem;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state, step control and pipeline handshake
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    stall     = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          accept  = 1'b1;
          stall   = 1'b1;
          state_d = special ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          step  = 1'b1;
          stall = 1'b1;
          last  = (cnt_q == CNT_W'(XLEN - 1));
          if (last) state_d = DONE;
        end
      end
      DONE: begin
        out_valid = !flush;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      f3_q        <= '0;
      rd_q        <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      op_q        <= '0;
      acc_q       <= '0;
      out_result  <= '0;
      out_rd_addr <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      f3_q    <= in_funct3;
      rd_q    <= in_rd_addr;
      neg_q_q <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
      op_q    <= is_div_in ? b_mag : a_mag;
      acc_q   <= {{XLEN{1'b0}}, (is_div_in ? a_mag : b_mag)};
      if (special) begin
        out_result  <= special_res;
        out_rd_addr <= in_rd_addr;
      end
    end else if (step) begin
      cnt_q <= CNT_W'(cnt_q + 1'b1);
      acc_q <= acc_step;
      if (last) begin
        out_result  <= final_res;
        out_rd_addr <= rd_q;
      end
    end
  end

endmodule
